// File: rtl/ad_data_buf_fifo.sv
// Single-clock FIFO buffering AD sample data toward the transmit path.
// Registered (non fall-through) read data; status flags decoded from a registered occupancy count.
module ad_data_buf_fifo #(
    parameter int unsigned DATA_WIDTH       = 8,
    parameter int unsigned ADDR_WIDTH       = 8,
    parameter int unsigned ALMOST_FULL_NUM  = 252,
    parameter int unsigned ALMOST_EMPTY_NUM = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  wr_full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_empty,
    output logic                  almost_empty
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DepthC       = Depth[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AlmostFullC  = ALMOST_FULL_NUM[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AlmostEmptyC = ALMOST_EMPTY_NUM[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] OneC         = (ADDR_WIDTH + 1)'(1);

    logic [DATA_WIDTH-1:0] mem [Depth];

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   occ_q, occ_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  wr_acc, rd_acc;

    // Acceptance uses the flags as seen at this edge, so a read cannot free room for a write
    // in the same cycle and a write cannot be bypassed to a read.
    assign wr_acc = wr_en & ~wr_full;
    assign rd_acc = rd_en & ~rd_empty;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        occ_d     = occ_q;
        rd_data_d = rd_data_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + OneC;
        end
        if (rd_acc) begin
            rd_ptr_d  = rd_ptr_q + OneC;
            rd_data_d = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
        end
        unique case ({wr_acc, rd_acc})
            2'b10:   occ_d = occ_q + OneC;
            2'b01:   occ_d = occ_q - OneC;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage is not reset; clearing the pointers is enough to discard its contents.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    assign rd_data      = rd_data_q;
    assign wr_full      = (occ_q == DepthC);
    assign rd_empty     = (occ_q == '0);
    assign almost_full  = (occ_q >= AlmostFullC);
    assign almost_empty = (occ_q <= AlmostEmptyC);

endmodule

// File: tb/tb_ad_data_buf_fifo.sv
// Directed self-checking bench for ad_data_buf_fifo: fill/overflow, drain/underflow,
// steady-state wrap, mid-operation reset and full-with-simultaneous-access.
module tb_ad_data_buf_fifo;

    logic       clk = 1'b0;
    logic       tb_rst = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic       wr_full, almost_full, rd_empty, almost_empty;
    logic [7:0] rd_data;

    int checks = 0;
    int errors = 0;

    ad_data_buf_fifo dut (
        .clk          (clk),
        .rst          (tb_rst),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .wr_full      (wr_full),
        .almost_full  (almost_full),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_empty     (rd_empty),
        .almost_empty (almost_empty)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tb_rst = 1'b1;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        tick();
        tb_rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL reset_rd_empty got %b want 1", rd_empty); end
        checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_almost_empty got %b want 1", almost_empty); end
        checks++; if (wr_full !== 1'b0) begin errors++; $display("FAIL reset_wr_full got %b want 0", wr_full); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full got %b want 0", almost_full); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
    endtask

    // Writes 257 words 0xFF, 0xFE, ...; the last one must be dropped.
    task automatic test_fill();
        int occ;
        do_reset();
        for (int i = 0; i < 257; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(255 - i);
            tick();
            occ = (i + 1 > 256) ? 256 : i + 1;
            checks++; if (wr_full !== (occ == 256)) begin errors++; $display("FAIL fill_wr_full[%0d] got %b want %b", i, wr_full, occ == 256); end
            checks++; if (almost_full !== (occ >= 252)) begin errors++; $display("FAIL fill_almost_full[%0d] got %b want %b", i, almost_full, occ >= 252); end
            checks++; if (almost_empty !== (occ <= 4)) begin errors++; $display("FAIL fill_almost_empty[%0d] got %b want %b", i, almost_empty, occ <= 4); end
            checks++; if (rd_empty !== 1'b0) begin errors++; $display("FAIL fill_rd_empty[%0d] got %b want 0", i, rd_empty); end
        end
        wr_en = 1'b0;
    endtask

    // Drains the full FIFO left by test_fill, then reads once more on empty.
    task automatic test_drain();
        int occ;
        for (int i = 0; i < 256; i++) begin
            rd_en = 1'b1;
            tick();
            occ = 255 - i;
            checks++; if (rd_data !== 8'(255 - i)) begin errors++; $display("FAIL drain_rd_data[%0d] got %h want %h", i, rd_data, 8'(255 - i)); end
            checks++; if (rd_empty !== (occ == 0)) begin errors++; $display("FAIL drain_rd_empty[%0d] got %b want %b", i, rd_empty, occ == 0); end
            checks++; if (almost_empty !== (occ <= 4)) begin errors++; $display("FAIL drain_almost_empty[%0d] got %b want %b", i, almost_empty, occ <= 4); end
            checks++; if (wr_full !== 1'b0) begin errors++; $display("FAIL drain_wr_full[%0d] got %b want 0", i, wr_full); end
            checks++; if (almost_full !== (occ >= 252)) begin errors++; $display("FAIL drain_almost_full[%0d] got %b want %b", i, almost_full, occ >= 252); end
        end
        tick();
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL underflow_rd_data got %h want 00", rd_data); end
        checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL underflow_rd_empty got %b want 1", rd_empty); end
        rd_en   = 1'b0;
        wr_en   = 1'b1;
        wr_data = 8'h55;
        tick();
        wr_en = 1'b0;
        checks++; if (rd_empty !== 1'b0) begin errors++; $display("FAIL after_underflow_rd_empty got %b want 0", rd_empty); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++; if (rd_data !== 8'h55) begin errors++; $display("FAIL after_underflow_rd_data got %h want 55", rd_data); end
        checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL after_underflow_empty got %b want 1", rd_empty); end
    endtask

    // Occupancy 10 held while reading and writing every cycle; pointers wrap past 256.
    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(i);
            tick();
        end
        for (int k = 0; k < 300; k++) begin
            wr_en   = 1'b1;
            rd_en   = 1'b1;
            wr_data = 8'(10 + k);
            tick();
            checks++; if (rd_data !== 8'(k)) begin errors++; $display("FAIL b2b_rd_data[%0d] got %h want %h", k, rd_data, 8'(k)); end
            checks++; if ({wr_full, almost_full, rd_empty, almost_empty} !== 4'b0000) begin
                errors++; $display("FAIL b2b_flags[%0d] got %b want 0000", k, {wr_full, almost_full, rd_empty, almost_empty});
            end
        end
        wr_en = 1'b0;
        for (int k = 300; k < 310; k++) begin
            rd_en = 1'b1;
            tick();
            checks++; if (rd_data !== 8'(k)) begin errors++; $display("FAIL b2b_tail[%0d] got %h want %h", k, rd_data, 8'(k)); end
        end
        rd_en = 1'b0;
        checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL b2b_final_empty got %b want 1", rd_empty); end
    endtask

    // Reset at occupancy 100 with both requests active; only later data may come out.
    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 100; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'hA0 + i);
            tick();
        end
        rd_en = 1'b1;
        tick();
        tb_rst  = 1'b1;
        wr_data = 8'h77;
        tick();
        tb_rst = 1'b0;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL midrst_rd_empty got %b want 1", rd_empty); end
        checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL midrst_almost_empty got %b want 1", almost_empty); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL midrst_rd_data got %h want 00", rd_data); end
        wr_en   = 1'b1;
        wr_data = 8'h3C;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++; if (rd_data !== 8'h3C) begin errors++; $display("FAIL midrst_readback got %h want 3c", rd_data); end
        checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL midrst_empty_after got %b want 1", rd_empty); end
    endtask

    // Full FIFO with simultaneous access: read succeeds, write is dropped.
    task automatic test_full_simul();
        do_reset();
        for (int i = 0; i < 256; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(i);
            tick();
        end
        rd_en   = 1'b1;
        wr_data = 8'hEE;
        tick();
        wr_en = 1'b0;
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL fullsim_rd_data got %h want 00", rd_data); end
        checks++; if (wr_full !== 1'b0) begin errors++; $display("FAIL fullsim_wr_full got %b want 0", wr_full); end
        checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL fullsim_almost_full got %b want 1", almost_full); end
        for (int i = 1; i < 256; i++) begin
            tick();
            checks++; if (rd_data !== 8'(i)) begin errors++; $display("FAIL fullsim_drain[%0d] got %h want %h", i, rd_data, 8'(i)); end
        end
        rd_en = 1'b0;
        checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL fullsim_final_empty got %b want 1", rd_empty); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_reset_mid();
        test_full_simul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
